// File: rtl/bpm_pkg.sv
// Shared FSM state type, default timing constants and BPM range helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bpm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_FAULT   = 2'd3
    } bpm_state_t;

    localparam int unsigned BPM_CLK_DIV_DEF = 40000;
    localparam int unsigned BPM_WARMUP_DEF  = 50;
    localparam int unsigned BPM_TIMEOUT_DEF = 75;
    localparam int unsigned BPM_MIN_DEF     = 30;
    localparam int unsigned BPM_MAX_DEF     = 220;

    function automatic logic bpm_in_range(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV cycles while run is high.
// Latency: first tick CLK_DIV-1 cycles after run rises from a cleared count.
// Backpressure: none; dropping run clears the count on the next edge.
module sample_tick_gen
    import bpm_pkg::*;
#(
    parameter int unsigned CLK_DIV = BPM_CLK_DIV_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == TC);
    assign tick = run && w_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!run || w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bpm_measure_ctrl.sv
// BPM measurement sequencer: warmup, range-checked capture, host hand-off, timeout fault.
// Latency: accepted reading on host_bpm next cycle (two cycles with BPM_MEASURE_CTRL_AVG_EN, 4-sample mean).
// Backpressure: none; unacknowledged host_bpm is overwritten and flagged via sticky overrun.
module bpm_measure_ctrl
    import bpm_pkg::*;
#(
    parameter int unsigned CLK_DIV         = BPM_CLK_DIV_DEF,
    parameter int unsigned WARMUP_SAMPLES  = BPM_WARMUP_DEF,
    parameter int unsigned TIMEOUT_SAMPLES = BPM_TIMEOUT_DEF,
    parameter int unsigned BPM_MIN         = BPM_MIN_DEF,
    parameter int unsigned BPM_MAX         = BPM_MAX_DEF
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       dp_en,
    input  logic [7:0] dp_bpm_value,
    input  logic       dp_bpm_valid,
    output logic       dp_bpm_copied,
    output logic [7:0] host_bpm,
    output logic       host_valid,
    input  logic       host_ack,
    output logic       busy,
    output logic       fault,
    output logic       overrun
);

    localparam int unsigned   WW        = $clog2(WARMUP_SAMPLES + 1);
    localparam int unsigned   TW        = $clog2(TIMEOUT_SAMPLES + 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_SAMPLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_SAMPLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_SAMPLES);
    localparam logic [7:0]    LO        = 8'(BPM_MIN);
    localparam logic [7:0]    HI        = 8'(BPM_MAX);

    bpm_state_t    r_state;
    logic          r_busy;
    logic          r_fault;
    logic [WW-1:0] r_warm_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_valid_q;
    logic          r_copied;
    logic [7:0]    r_host_bpm;
    logic          r_host_vld;
    logic          r_overrun;

    logic          w_run;
    logic          w_tick;
    logic          w_rise;
    logic          w_accept;
    logic          w_present;
    logic [7:0]    w_present_bpm;

    // A stop cycle clears the divider so IDLE always starts from a zero count.
    assign w_run    = ((r_state == ST_WARMUP) || (r_state == ST_MEASURE)) && !stop;
    assign w_rise   = dp_bpm_valid && !r_valid_q;
    assign w_accept = (r_state == ST_MEASURE) && w_rise && bpm_in_range(dp_bpm_value, LO, HI);

    sample_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
            r_warm_cnt <= '0;
            r_to_cnt   <= '0;
        end else if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        r_state    <= ST_WARMUP;
                        r_busy     <= 1'b1;
                        r_fault    <= 1'b0;
                        r_warm_cnt <= '0;
                    end
                end
                ST_WARMUP: begin
                    if (w_tick) begin
                        if (r_warm_cnt == WARM_LAST) begin
                            r_state  <= ST_MEASURE;
                            r_to_cnt <= '0;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + WW'(1);
                        end
                    end
                end
                ST_MEASURE: begin
                    if (w_accept) begin
                        r_to_cnt <= '0;
                    end else if (w_tick) begin
                        if (r_to_cnt != TO_MAX) begin
                            r_to_cnt <= r_to_cnt + TW'(1);
                        end
                        if (r_to_cnt == TO_LAST) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

`ifdef BPM_MEASURE_CTRL_AVG_EN
    logic [3:0][7:0] r_hist;
    logic [1:0]      r_fill;
    logic            r_avg_vld;
    logic [9:0]      w_sum;

    // History window restarts every warmup so stale pre-fault samples never leak into the mean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            r_avg_vld <= 1'b0;
            if (r_state == ST_WARMUP) begin
                r_fill <= '0;
            end else if (w_accept) begin
                r_hist <= {r_hist[2:0], dp_bpm_value};
                if (r_fill == 2'd3) begin
                    r_avg_vld <= 1'b1;
                end else begin
                    r_fill <= r_fill + 2'd1;
                end
            end
        end
    end

    assign w_sum         = {2'b00, r_hist[0]} + {2'b00, r_hist[1]}
                         + {2'b00, r_hist[2]} + {2'b00, r_hist[3]};
    assign w_present     = r_avg_vld && !stop;
    assign w_present_bpm = w_sum[9:2];
`else
    assign w_present     = w_accept && !stop;
    assign w_present_bpm = dp_bpm_value;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q  <= 1'b0;
            r_copied   <= 1'b0;
            r_host_bpm <= '0;
            r_host_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_valid_q <= dp_bpm_valid;
            r_copied  <= w_rise && (r_state != ST_IDLE);
            if (start) begin
                r_overrun <= 1'b0;
            end else if (w_present && r_host_vld && !host_ack) begin
                r_overrun <= 1'b1;
            end
            if (stop) begin
                r_host_vld <= 1'b0;
            end else if (w_present) begin
                r_host_bpm <= w_present_bpm;
                r_host_vld <= 1'b1;
            end else if (host_ack) begin
                r_host_vld <= 1'b0;
            end
        end
    end

    assign dp_en         = w_tick;
    assign dp_bpm_copied = r_copied;
    assign host_bpm      = r_host_bpm;
    assign host_valid    = r_host_vld;
    assign busy          = r_busy;
    assign fault         = r_fault;
    assign overrun       = r_overrun;

endmodule
